// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared encodings for the memory-mapped down-counter timer
package timer_pkg;

    // Controller states; encodings are visible to anyone probing the state register
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_CNT  = 2'b10,
        ST_INT  = 2'b11
    } state_e;

    // Word offsets inside the timer's address window
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // Mode codes; anything other than RELOAD behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    function automatic logic is_reload(input logic [3:0] ctrl);
        return ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - programmable down-counter timer with one-shot/auto-reload and maskable irq
module timer_counter
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic ctrl_wr;
    logic preset_wr;
    logic en_now;

    assign ctrl_wr   = we && (addr == OFF_CTRL);
    assign preset_wr = we && (addr == OFF_PRESET);

    // Outside IDLE a CPU write to CTRL on the same edge overrides the stored EN,
    // so the CPU always wins against the hardware. IDLE looks only at the stored
    // EN so that the edge which sets EN is followed by exactly one IDLE cycle.
    assign en_now = ctrl_wr ? wdata[CTRL_EN] : ctrl_q[CTRL_EN];

    // State register and all architectural registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // Next-state logic: counting FSM first, then CPU register writes on top
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN]) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!en_now) begin
                    state_d = ST_IDLE;
                end else begin
                    count_d = preset_q;
                    state_d = ST_CNT;
                end
            end
            ST_CNT: begin
                if (!en_now) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // Count of 1 or 0 expires here; 0 covers PRESET = 0
                    count_d    = 32'd0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                if (!en_now) begin
                    state_d = ST_IDLE;
                end else if (is_reload(ctrl_q)) begin
                    irq_flag_d = 1'b0;
                    state_d    = ST_LOAD;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // CPU writes take priority over the hardware updates above
        if (ctrl_wr) begin
            ctrl_d = wdata[3:0];
        end
        if (preset_wr) begin
            preset_d = wdata;
        end
        if (ctrl_wr || preset_wr) begin
            irq_flag_d = 1'b0;
        end
    end

    // Zero-latency register readback
    always_comb begin
        rdata = 32'd0;
        unique case (addr)
            OFF_CTRL:   rdata = {28'd0, ctrl_q};
            OFF_PRESET: rdata = preset_q;
            OFF_COUNT:  rdata = count_q;
            default:    rdata = 32'd0;
        endcase
    end

    assign irq = irq_flag_q && ctrl_q[CTRL_IM];

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped programmable down-counter timer on the CPU's peripheral bridge. The bridge decodes the timer's address window and forwards a word offset, write enable and write data. It reads back the timer's registers and routes the timer's interrupt onto `HWInt[2]`, which feeds CP0. Two modes are supported: one-shot and auto-reload. The interrupt is maskable.

## Interface
- Parameters: none.
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `addr` in 2: word offset within the window (byte address bits [3:2]). 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `we` in 1: write strobe, sampled on the rising edge of `clk`.
- `wdata` in 32: write data.
- `rdata` out 32: combinational read of the register selected by `addr`.
- `irq` out 1: interrupt request to `HWInt[2]`.

## Operation
- CTRL[3:0] is read/write; CTRL[31:4] read as 0.
  - Bit 0 EN: enable.
  - Bits [2:1] MODE: 00 = one-shot, 01 = auto-reload; 10 and 11 behave as 00.
  - Bit 3 IM: interrupt mask, 1 = enabled.
- PRESET[31:0] is read/write.
- COUNT[31:0] is read-only; writes are ignored. Offset 3 reads 0 and ignores writes.
- Internal `irq_flag`. The output is `irq = irq_flag & CTRL.IM`.
- Any write to CTRL or PRESET clears `irq_flag`.
- State machine, 2 bits:
  - IDLE: if EN = 1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If EN = 0: go to IDLE; COUNT holds its value.
    - Else if COUNT > 1: COUNT <= COUNT - 1.
    - Else (COUNT is 1 or 0): COUNT <= 0, `irq_flag` <= 1, go to INT.
  - INT:
    - Mode one-shot: CTRL.EN <= 0, go to IDLE; `irq_flag` holds.
    - Mode auto-reload: `irq_flag` <= 0, go to LOAD.
- Simultaneous events:
  - A CPU CTRL write in the same cycle as INT's hardware clear of EN: the CPU write wins.
  - A PRESET write during CNT does not alter the current count. It takes effect at the next LOAD.
  - A CTRL write with EN = 0 during LOAD or INT: go to IDLE next edge. In INT, `irq_flag` is cleared by the write.
- Subtraction is unsigned 32-bit. COUNT never wraps below 0.
- PRESET = 0 counts as an immediate expiry: a single CNT cycle, then INT.

## Timing
- Reset values: CTRL = 0, PRESET = 0, COUNT = 0, state = IDLE, `irq_flag` = 0. Therefore `irq` = 0 and `rdata` reflects zeroed registers.
- `rdata` has zero latency: it is combinational from `addr` and the registers.
- Register writes are visible on `rdata` the cycle after the write edge.
- Let W be the edge that sets EN with PRESET = N ≥ 1:
  - W+1: LOAD.
  - W+2: CNT with COUNT = N.
  - W+1+N: COUNT = 1.
  - W+2+N: INT, COUNT = 0, `irq` rises (if IM = 1).
- One-shot: at W+3+N the state is IDLE and EN = 0. `irq` stays high until a CTRL or PRESET write.
- Auto-reload: `irq` is high for exactly one cycle, then repeats every N+2 cycles.
- Reset asserted mid-count returns everything to reset values immediately, without waiting for a clock edge.

## Structure
- Shared package `timer_pkg`:
  - State encodings: IDLE = 2'b00, LOAD = 2'b01, CNT = 2'b10, INT = 2'b11.
  - Register offsets: CTRL = 0, PRESET = 1, COUNT = 2.
  - CTRL bit positions: EN = 0, MODE = [2:1], IM = 3.
  - Mode codes: ONESHOT = 2'b00, RELOAD = 2'b01.
- Single module; no sub-module. The bridge owns address decode and chip select.

## Test plan
- Reset: assert `reset` asynchronously mid-count -> `irq` = 0 and CTRL/PRESET/COUNT all read 0 before the next edge.
- One-shot: PRESET = 5, CTRL = 4'b1001 at edge W -> `irq` rises at W+7 and stays high. CTRL reads 4'b1000 at W+8. A PRESET write at W+12 drops `irq` next cycle.
- Auto-reload: PRESET = 3, CTRL = 4'b1011 -> one-cycle `irq` pulses at W+5, W+10, W+15. COUNT reads 3, 2, 1, 0 sequence between pulses.
- Mask: PRESET = 2, CTRL = 4'b0001 -> `irq` stays 0. Then write CTRL = 4'b1000 after expiry -> `irq` stays 0, because the CTRL write clears the flag.
- Pause: PRESET = 10, enable, write CTRL EN = 0 when COUNT = 6 -> COUNT holds 6 in IDLE. Re-enable -> reloads 10.
- Edge cases:
  - PRESET = 0 in one-shot -> `irq` at W+3.
  - COUNT write at offset 2 is ignored.
  - Offset 3 reads 0.
  - CTRL write with EN = 1 in the INT cycle keeps EN = 1.
